// File: rtl/vx_pending_instr_tracker.sv
// Per-warp in-flight instruction counters feeding the CSR alm_empty query and the busy/empty masks.
// Optional VX_PENDING_ERR_EN adds a sticky ovf_err flag for saturated increments/decrements.
`ifdef VX_PENDING_ERR_EN
`ifndef RUNTIME_ASSERT
`define RUNTIME_ASSERT(cond, msg) assert (cond) else $error msg
`endif
`endif

module vx_pending_instr_tracker #(
  parameter int NUM_WARPS       = 4,
  parameter int WID_WIDTH       = 2,
  parameter int CTR_WIDTH       = 6,
  parameter int ALM_EMPTY_LEVEL = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_valid,
  input  logic [WID_WIDTH-1:0] issue_wid,
  input  logic                 commit_valid,
  input  logic [WID_WIDTH-1:0] commit_wid,
  input  logic                 commit_eop,
  input  logic [WID_WIDTH-1:0] alm_empty_wid,
  output logic                 alm_empty,
  output logic [NUM_WARPS-1:0] busy_mask,
  output logic [NUM_WARPS-1:0] empty_mask,
  output logic                 ovf_err
);

  localparam logic [CTR_WIDTH-1:0] CTR_MAX  = {CTR_WIDTH{1'b1}};
  localparam logic [CTR_WIDTH-1:0] CTR_ZERO = {CTR_WIDTH{1'b0}};
  localparam logic [CTR_WIDTH-1:0] CTR_ONE  = CTR_WIDTH'(1);
  localparam logic [CTR_WIDTH-1:0] CTR_ALM  = CTR_WIDTH'(ALM_EMPTY_LEVEL);

  logic [CTR_WIDTH-1:0] pending_r     [NUM_WARPS];
  logic [CTR_WIDTH-1:0] pending_nxt_s [NUM_WARPS];
  logic [NUM_WARPS-1:0] inc_s;
  logic [NUM_WARPS-1:0] dec_s;
  logic [NUM_WARPS-1:0] busy_s;
  logic [NUM_WARPS-1:0] empty_s;
  logic                 alm_empty_s;

  // Decode issue and final-packet commit handshakes into per-warp up/down requests
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      inc_s[w] = issue_valid && (issue_wid == WID_WIDTH'(w));
      dec_s[w] = commit_valid && commit_eop && (commit_wid == WID_WIDTH'(w));
    end
  end

  // Saturating next count; same-warp issue+commit cancels out
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      pending_nxt_s[w] = pending_r[w];
      case ({inc_s[w], dec_s[w]})
        2'b10: begin
          if (pending_r[w] != CTR_MAX) begin
            pending_nxt_s[w] = pending_r[w] + CTR_ONE;
          end else begin
            pending_nxt_s[w] = pending_r[w];
          end
        end
        2'b01: begin
          if (pending_r[w] != CTR_ZERO) begin
            pending_nxt_s[w] = pending_r[w] - CTR_ONE;
          end else begin
            pending_nxt_s[w] = pending_r[w];
          end
        end
        default: pending_nxt_s[w] = pending_r[w];
      endcase
    end
  end

  // Counter state, discarded immediately on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pending_r[w] <= CTR_ZERO;
      end
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        pending_r[w] <= pending_nxt_s[w];
      end
    end
  end

  // Status decodes straight off the registered counters
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      busy_s[w]  = (pending_r[w] != CTR_ZERO);
      empty_s[w] = (pending_r[w] == CTR_ZERO);
    end
  end

  // CSR query: one compare behind a mux, nothing else in the ready path
  always_comb begin
    alm_empty_s = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (alm_empty_wid == WID_WIDTH'(w)) begin
        alm_empty_s = (pending_r[w] == CTR_ALM);
      end else begin
        alm_empty_s = alm_empty_s;
      end
    end
  end

  assign busy_mask  = busy_s;
  assign empty_mask = empty_s;
  assign alm_empty  = alm_empty_s;

`ifdef VX_PENDING_ERR_EN
  logic [NUM_WARPS-1:0] ovf_s;
  logic [NUM_WARPS-1:0] unf_s;
  logic                 ovf_err_r;

  // Flag saturated increments and decrements at zero
  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      ovf_s[w] = inc_s[w] && !dec_s[w] && (pending_r[w] == CTR_MAX);
      unf_s[w] = dec_s[w] && !inc_s[w] && (pending_r[w] == CTR_ZERO);
    end
  end

  // Sticky error; only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_err_r <= 1'b0;
    end else if (|(ovf_s | unf_s)) begin
      ovf_err_r <= 1'b1;
    end else begin
      ovf_err_r <= ovf_err_r;
    end
  end

  assign ovf_err = ovf_err_r;

`ifndef SYNTHESIS
  vx_pending_instr_tracker_chk #(
    .NUM_WARPS (NUM_WARPS)
  ) u_chk (
    .clk   (clk),
    .reset (reset),
    .ovf   (ovf_s),
    .unf   (unf_s)
  );
`endif
`else
  assign ovf_err = 1'b0;
`endif

endmodule

`ifdef VX_PENDING_ERR_EN
`ifndef SYNTHESIS
// Simulation-only reporter naming the warp and event behind a counter error.
module vx_pending_instr_tracker_chk #(
  parameter int NUM_WARPS = 4
) (
  input logic                 clk,
  input logic                 reset,
  input logic [NUM_WARPS-1:0] ovf,
  input logic [NUM_WARPS-1:0] unf
);

  // Report each overflow/underflow as it is committed to the counter
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        `RUNTIME_ASSERT(!ovf[w], ("pending counter overflow on warp %0d", w));
        `RUNTIME_ASSERT(!unf[w], ("pending counter underflow on warp %0d", w));
      end
    end
  end

endmodule
`endif
`endif

// File: tb/tb_vx_pending_instr_tracker.sv
// Scoreboard bench: a 6-bit and a 2-bit instance share stimulus; a counter model predicts both.
module tb_vx_pending_instr_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic       issue_valid;
  logic [1:0] issue_wid;
  logic       commit_valid;
  logic [1:0] commit_wid;
  logic       commit_eop;
  logic [1:0] alm_empty_wid;
  logic       alm6, alm2, ovf6, ovf2;
  logic [3:0] busy6, empty6, busy2, empty2;

  always #5 clk = ~clk;

  vx_pending_instr_tracker u_dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wid(issue_wid),
    .commit_valid(commit_valid), .commit_wid(commit_wid), .commit_eop(commit_eop),
    .alm_empty_wid(alm_empty_wid), .alm_empty(alm6),
    .busy_mask(busy6), .empty_mask(empty6), .ovf_err(ovf6)
  );

  vx_pending_instr_tracker #(.CTR_WIDTH(2)) u_dut_small (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_wid(issue_wid),
    .commit_valid(commit_valid), .commit_wid(commit_wid), .commit_eop(commit_eop),
    .alm_empty_wid(alm_empty_wid), .alm_empty(alm2),
    .busy_mask(busy2), .empty_mask(empty2), .ovf_err(ovf2)
  );

`ifdef VX_PENDING_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0] busy6, empty6, alm6, busy2, empty2, alm2;
    logic       ovf6, ovf2;
  } exp_t;

  exp_t exp_q[$];
  int   cnt6[4];
  int   cnt2[4];
  bit   err6, err2;
  int   total = 0;
  int   bad   = 0;

  function automatic exp_t snapshot();
    exp_t e;
    for (int w = 0; w < 4; w++) begin
      e.busy6[w]  = (cnt6[w] != 0);
      e.empty6[w] = (cnt6[w] == 0);
      e.alm6[w]   = (cnt6[w] == 1);
      e.busy2[w]  = (cnt2[w] != 0);
      e.empty2[w] = (cnt2[w] == 0);
      e.alm2[w]   = (cnt2[w] == 1);
    end
    e.ovf6 = ERR_EN ? err6 : 1'b0;
    e.ovf2 = ERR_EN ? err2 : 1'b0;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs(input string tag, input exp_t e, input bit sweep);
    chk({tag, ".busy6"},  32'(busy6),  32'(e.busy6));
    chk({tag, ".empty6"}, 32'(empty6), 32'(e.empty6));
    chk({tag, ".busy2"},  32'(busy2),  32'(e.busy2));
    chk({tag, ".empty2"}, 32'(empty2), 32'(e.empty2));
    chk({tag, ".ovf6"},   32'(ovf6),   32'(e.ovf6));
    chk({tag, ".ovf2"},   32'(ovf2),   32'(e.ovf2));
    if (sweep) begin
      for (int q = 0; q < 4; q++) begin
        alm_empty_wid = 2'(q);
        #1;
        chk($sformatf("%s.alm6[%0d]", tag, q), 32'(alm6), 32'(e.alm6[q]));
        chk($sformatf("%s.alm2[%0d]", tag, q), 32'(alm2), 32'(e.alm2[q]));
      end
    end
  endtask

  task automatic model_update(input bit iv, input int iw, input bit cv, input int cw, input bit ce);
    bit inc, dec;
    for (int w = 0; w < 4; w++) begin
      inc = iv && (iw == w);
      dec = cv && ce && (cw == w);
      if (inc && !dec) begin
        if (cnt6[w] == 63) err6 = 1'b1; else cnt6[w]++;
        if (cnt2[w] == 3)  err2 = 1'b1; else cnt2[w]++;
      end else if (dec && !inc) begin
        if (cnt6[w] == 0) err6 = 1'b1; else cnt6[w]--;
        if (cnt2[w] == 0) err2 = 1'b1; else cnt2[w]--;
      end
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 4; w++) begin
      cnt6[w] = 0;
      cnt2[w] = 0;
    end
    err6 = 1'b0;
    err2 = 1'b0;
  endtask

  // One clocked transaction: drive, confirm no bypass before the edge, then score after it.
  task automatic step(input string tag, input bit iv, input int iw, input bit cv, input int cw, input bit ce);
    exp_t pre;
    exp_t e;
    pre = snapshot();
    issue_valid  = iv;
    issue_wid    = 2'(iw);
    commit_valid = cv;
    commit_wid   = 2'(cw);
    commit_eop   = ce;
    model_update(iv, iw, cv, cw, ce);
    exp_q.push_back(snapshot());
    #1;
    check_outputs({tag, ".pre"}, pre, 1'b0);
    @(posedge clk);
    #1;
    issue_valid  = 1'b0;
    commit_valid = 1'b0;
    commit_eop   = 1'b0;
    if (exp_q.size() == 0) begin
      chk({tag, ".queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check_outputs(tag, e, 1'b1);
    end
  endtask

  initial begin
    reset         = 1'b1;
    issue_valid   = 1'b0;
    issue_wid     = 2'd0;
    commit_valid  = 1'b0;
    commit_wid    = 2'd0;
    commit_eop    = 1'b0;
    alm_empty_wid = 2'd0;
    model_reset();
    #1;
    check_outputs("reset_state", snapshot(), 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Build pending[2]=5, then hit reset between edges
    for (int i = 0; i < 5; i++) step($sformatf("fill2_%0d", i), 1'b1, 2, 1'b0, 0, 1'b0);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("async_reset_masks", snapshot(), 1'b0);
    check_outputs("async_reset_full", snapshot(), 1'b1);
    @(negedge clk);
    reset = 1'b0;

    // Three issues then two final commits on warp 1 leave exactly one pending
    for (int i = 0; i < 3; i++) step($sformatf("iss1_%0d", i), 1'b1, 1, 1'b0, 0, 1'b0);
    for (int i = 0; i < 2; i++) step($sformatf("cmt1_%0d", i), 1'b0, 0, 1'b1, 1, 1'b1);

    // Same-warp issue+commit is net zero; different warps update together
    step("pre3_a", 1'b1, 3, 1'b0, 0, 1'b0);
    step("pre3_b", 1'b1, 3, 1'b0, 0, 1'b0);
    step("pre0",   1'b1, 0, 1'b0, 0, 1'b0);
    step("same3",  1'b1, 3, 1'b1, 3, 1'b1);
    step("diff30", 1'b1, 3, 1'b1, 0, 1'b1);
    for (int i = 0; i < 3; i++) step($sformatf("drain3_%0d", i), 1'b0, 0, 1'b1, 3, 1'b1);

    // Non-final packets never move the counter
    step("pre2", 1'b1, 2, 1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) step($sformatf("noeop2_%0d", i), 1'b0, 0, 1'b1, 2, 1'b0);
    step("eop2", 1'b0, 0, 1'b1, 2, 1'b1);

    // Saturation on the narrow instance, error stays through later commits
    for (int i = 0; i < 4; i++) step($sformatf("sat0_%0d", i), 1'b1, 0, 1'b0, 0, 1'b0);
    step("after_sat_a", 1'b0, 0, 1'b1, 0, 1'b1);
    step("after_sat_b", 1'b0, 0, 1'b1, 0, 1'b1);

    // Decrement at zero holds
    step("dec1_to0", 1'b0, 0, 1'b1, 1, 1'b1);
    step("dec1_at0", 1'b0, 0, 1'b1, 1, 1'b1);
    step("reissue1", 1'b1, 1, 1'b0, 0, 1'b0);

    // Reset clears counts and the sticky flag
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_outputs("final_reset", snapshot(), 1'b1);
    @(negedge clk);
    reset = 1'b0;
    step("post_reset", 1'b1, 0, 1'b0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
